// File: rtl/gpr_wb_arbiter.sv
// GPR writeback arbiter: NREQ requesters share two registered GPR write ports.
// Each requester has a one-entry hold for writes that lose arbitration. stall
// freezes upstream while any hold is occupied. Same-address writes collapse so
// the youngest value wins, and a lookup port forwards pending writes to operand
// fetch.
module gpr_wb_arbiter #(
  parameter int NREQ         = 4,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter bit ZERO_DISCARD = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [1:0]               wr_en,
  output logic [2*ADDR_W-1:0]      wr_addr,
  output logic [2*DATA_W-1:0]      wr_data,
  output logic                     stall,
  input  logic [ADDR_W-1:0]        q_addr,
  output logic                     q_hit,
  output logic [DATA_W-1:0]        q_data
);

  // Candidate slots 0..NREQ-1 are hold entries (older).
  // Slots NREQ..2*NREQ-1 are new requests (younger).
  // Within each class, a higher slot index is younger.
  localparam int NC = 2 * NREQ;

  logic [NREQ-1:0]              hold_v_q;
  logic [NREQ-1:0][ADDR_W-1:0]  hold_a_q;
  logic [NREQ-1:0][DATA_W-1:0]  hold_d_q;
  logic [1:0]                   wr_en_q;
  logic [1:0][ADDR_W-1:0]       wr_addr_q;
  logic [1:0][DATA_W-1:0]       wr_data_q;

  logic [NC-1:0]                c_v, sq, live, gnt;
  logic [NC-1:0][ADDR_W-1:0]    c_a;
  logic [NC-1:0][DATA_W-1:0]    c_d;
  logic                         g0_v, g1_v;
  logic [ADDR_W-1:0]            g0_a, g1_a;
  logic [DATA_W-1:0]            g0_d, g1_d;

  assign req_ready = ~hold_v_q;
  assign stall     = |hold_v_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  // Build the candidate list, collapse WAW hazards, and pick up to two grants in age order.
  always_comb begin
    c_v  = '0;
    c_a  = '0;
    c_d  = '0;
    sq   = '0;
    gnt  = '0;
    g0_v = 1'b0;
    g1_v = 1'b0;
    g0_a = '0;
    g1_a = '0;
    g0_d = '0;
    g1_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      c_v[i]      = hold_v_q[i];
      c_a[i]      = hold_a_q[i];
      c_d[i]      = hold_d_q[i];
      c_a[NREQ+i] = req_addr[i*ADDR_W +: ADDR_W];
      c_d[NREQ+i] = req_data[i*DATA_W +: DATA_W];
      // An accepted write to r0 is consumed here and never competes.
      c_v[NREQ+i] = req_valid[i] & ~hold_v_q[i] &
                    ~(ZERO_DISCARD && (c_a[NREQ+i] == '0));
    end
    for (int k = 0; k < NC; k++)
      for (int j = k + 1; j < NC; j++)
        if (c_v[k] && c_v[j] && (c_a[j] == c_a[k])) sq[k] = 1'b1;
    live = c_v & ~sq;
    for (int k = 0; k < NC; k++) begin
      if (live[k]) begin
        if (!g0_v) begin
          g0_v = 1'b1; g0_a = c_a[k]; g0_d = c_d[k]; gnt[k] = 1'b1;
        end else if (!g1_v) begin
          g1_v = 1'b1; g1_a = c_a[k]; g1_d = c_d[k]; gnt[k] = 1'b1;
        end
      end
    end
  end

  // Register the port writes and update the hold entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q  <= '0;
      hold_a_q  <= '0;
      hold_d_q  <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= {g1_v, g0_v};
      if (g0_v) begin
        wr_addr_q[0] <= g0_a;
        wr_data_q[0] <= g0_d;
      end
      if (g1_v) begin
        wr_addr_q[1] <= g1_a;
        wr_data_q[1] <= g1_d;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (hold_v_q[i]) begin
          if (gnt[i] || sq[i]) hold_v_q[i] <= 1'b0;
        end else if (live[NREQ+i] && !gnt[NREQ+i]) begin
          hold_v_q[i] <= 1'b1;
          hold_a_q[i] <= c_a[NREQ+i];
          hold_d_q[i] <= c_d[NREQ+i];
        end
      end
    end
  end

  // Forwarding lookup. Lowest priority is assigned first and later matches override.
  // Order of overrides: port 0, then port 1, then hold entries (youngest).
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    for (int p = 0; p < 2; p++)
      if (wr_en_q[p] && (wr_addr_q[p] == q_addr)) begin
        q_hit  = 1'b1;
        q_data = wr_data_q[p];
      end
    for (int i = 0; i < NREQ; i++)
      if (hold_v_q[i] && (hold_a_q[i] == q_addr)) begin
        q_hit  = 1'b1;
        q_data = hold_d_q[i];
      end
    if (ZERO_DISCARD && (q_addr == '0)) begin
      q_hit  = 1'b0;
      q_data = '0;
    end
  end

endmodule
